// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and stall accounting.
//
// Holds the decoded instruction and its register operands between decode and the EX ALU.
// Bubbles are inserted on load-use stalls (stage holds and does not issue) and on flushes
// (stage is killed). Operands are muxed from the last issued ALU result (EX->EX), from MEM
// load data, or from the register-file values captured at decode.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid/pc/inst         decode slot instruction
//   id_rs1_data/rs2_data     register-file reads
//   id_imm                   sign-extended immediate
//   stall, flush             hazard-unit controls for the current cycle
//   fwd_ex_ex1/2             select last EX result for op1/op2
//   fwd_mem_ex1/2            select MEM load data for op1/op2
//   mem_rdata, ex_alu_result forwarding sources
//   id_ready                 decode may advance (~stall)
//   ex_valid/pc/inst/imm     stage contents presented to EX
//   ex_op1, ex_op2           forwarded operands
//   stall_cycles             saturating count of stalled cycles
//   stall_timeout            sticky: stall run exceeded STALL_LIMIT
module id_ex_operand_stage #(
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  parameter int unsigned STALL_LIMIT = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      id_rs1_data,
  input  logic [31:0]      id_rs2_data,
  input  logic [31:0]      id_imm,
  input  logic             stall,
  input  logic             fwd_ex_ex1,
  input  logic             fwd_ex_ex2,
  input  logic             fwd_mem_ex1,
  input  logic             fwd_mem_ex2,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      ex_alu_result,
  input  logic             flush,
  output logic             id_ready,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_inst,
  output logic [31:0]      ex_op1,
  output logic [31:0]      ex_op2,
  output logic [31:0]      ex_imm,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  // Run counter saturates one past the limit so long stalls cannot wrap it back under.
  localparam int unsigned     RunW     = $clog2(STALL_LIMIT + 2);
  localparam logic [RunW-1:0] RunLimit = RunW'(STALL_LIMIT);
  localparam logic [RunW-1:0] RunMax   = RunW'(STALL_LIMIT + 1);

  logic             valid_q, valid_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      imm_q, imm_d;
  logic [31:0]      prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             timeout_q, timeout_d;
  logic             issue;

  assign issue = valid_q & ~stall & ~flush;

  // Stage register next state: flush beats stall beats load.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (!stall) begin
      valid_d = id_valid;
      pc_d    = id_pc;
      inst_d  = id_inst;
      rs1_d   = id_rs1_data;
      rs2_d   = id_rs2_data;
      imm_d   = id_imm;
    end
  end

  // Only issued instructions update the forwarding source, so bubbles never corrupt it.
  always_comb begin
    prev_d = issue ? ex_alu_result : prev_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    if (stall) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (run_q != RunMax) run_d = run_q + RunW'(1);
      // run_q + 1 > STALL_LIMIT
      if (run_q >= RunLimit) timeout_d = 1'b1;
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= NOP_INST;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  // Forwarding is honoured during stall so operands are correct for the replay.
  always_comb begin
    if (fwd_ex_ex1)       ex_op1 = prev_q;
    else if (fwd_mem_ex1) ex_op1 = mem_rdata;
    else                  ex_op1 = rs1_q;
    if (fwd_ex_ex2)       ex_op2 = prev_q;
    else if (fwd_mem_ex2) ex_op2 = mem_rdata;
    else                  ex_op2 = rs2_q;
  end

  assign id_ready      = ~stall;
  assign ex_valid      = issue;
  assign ex_pc         = pc_q;
  assign ex_inst       = inst_q;
  assign ex_imm        = imm_q;
  assign stall_cycles  = cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_inst, id_rs1_data, id_rs2_data, id_imm;
  logic        stall, flush;
  logic        fwd_ex_ex1, fwd_ex_ex2, fwd_mem_ex1, fwd_mem_ex2;
  logic [31:0] mem_rdata, ex_alu_result;

  logic        id_ready, ex_valid, stall_timeout;
  logic [31:0] ex_pc, ex_inst, ex_op1, ex_op2, ex_imm;
  logic [15:0] stall_cycles;

  logic        s_id_ready, s_ex_valid, s_stall_timeout;
  logic [31:0] s_ex_pc, s_ex_inst, s_ex_op1, s_ex_op2, s_ex_imm;
  logic [3:0]  s_stall_cycles;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model of the stage contents and counters.
  bit          m_valid, m_known, m_to;
  logic [31:0] m_pc, m_inst, m_rs1, m_rs2, m_imm, m_prev;
  int          m_cnt, m_cnt4, m_run;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.NOP_INST(Nop), .STALL_LIMIT(Limit), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .stall(stall),
    .fwd_ex_ex1(fwd_ex_ex1), .fwd_ex_ex2(fwd_ex_ex2), .fwd_mem_ex1(fwd_mem_ex1),
    .fwd_mem_ex2(fwd_mem_ex2), .mem_rdata(mem_rdata), .ex_alu_result(ex_alu_result),
    .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_inst(ex_inst), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  // Narrow counter instance to exercise saturation.
  id_ex_operand_stage #(.NOP_INST(Nop), .STALL_LIMIT(Limit), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .stall(stall),
    .fwd_ex_ex1(fwd_ex_ex1), .fwd_ex_ex2(fwd_ex_ex2), .fwd_mem_ex1(fwd_mem_ex1),
    .fwd_mem_ex2(fwd_mem_ex2), .mem_rdata(mem_rdata), .ex_alu_result(ex_alu_result),
    .flush(flush), .id_ready(s_id_ready), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
    .ex_inst(s_ex_inst), .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .ex_imm(s_ex_imm),
    .stall_cycles(s_stall_cycles), .stall_timeout(s_stall_timeout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_known = 1; m_to = 0;
    m_pc = '0; m_inst = Nop; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_prev = '0;
    m_cnt = 0; m_cnt4 = 0; m_run = 0;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = '0; id_inst = Nop; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; stall = 0; flush = 0; fwd_ex_ex1 = 0; fwd_ex_ex2 = 0;
    fwd_mem_ex1 = 0; fwd_mem_ex2 = 0; mem_rdata = '0; ex_alu_result = '0;
  endtask

  task automatic check_all();
    logic [31:0] e1, e2;
    bit issue;
    issue = m_valid && !stall && !flush;
    e1 = fwd_ex_ex1 ? m_prev : (fwd_mem_ex1 ? mem_rdata : m_rs1);
    e2 = fwd_ex_ex2 ? m_prev : (fwd_mem_ex2 ? mem_rdata : m_rs2);
    check("id_ready", {31'b0, id_ready}, {31'b0, !stall});
    check("ex_valid", {31'b0, ex_valid}, {31'b0, issue});
    check("ex_inst", ex_inst, m_inst);
    check("stall_cycles", {16'b0, stall_cycles}, m_cnt);
    check("stall_cycles_w4", {28'b0, s_stall_cycles}, m_cnt4);
    check("stall_timeout", {31'b0, stall_timeout}, {31'b0, m_to});
    if (m_known) begin
      check("ex_pc", ex_pc, m_pc);
      check("ex_imm", ex_imm, m_imm);
    end
    if (m_known || fwd_ex_ex1 || fwd_mem_ex1) check("ex_op1", ex_op1, e1);
    if (m_known || fwd_ex_ex2 || fwd_mem_ex2) check("ex_op2", ex_op2, e2);
  endtask

  // Apply model effects of one clock edge using the inputs held across it.
  task automatic model_edge();
    if (m_valid && !stall && !flush) m_prev = ex_alu_result;
    if (stall) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
      m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
      m_run++;
      if (m_run > Limit) m_to = 1;
    end else begin
      m_run = 0;
    end
    if (flush) begin
      m_valid = 0; m_inst = Nop; m_known = 0;
    end else if (!stall) begin
      m_valid = id_valid; m_pc = id_pc; m_inst = id_inst;
      m_rs1 = id_rs1_data; m_rs2 = id_rs2_data; m_imm = id_imm; m_known = 1;
    end
  endtask

  // Called just after a negedge with inputs set; returns just after the next negedge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    step();

    // Plain issue
    id_valid = 1; id_pc = 32'h100; id_inst = 32'h0050_0093; id_rs1_data = 5;
    id_rs2_data = 7; id_imm = 3; ex_alu_result = 32'h2A;
    step();
    id_pc = 32'h104; id_inst = 32'h0020_8133; id_rs1_data = 1; id_rs2_data = 2;
    #1;
    check("plain_valid", {31'b0, ex_valid}, 32'd1);
    check("plain_pc", ex_pc, 32'h100);
    check("plain_op1", ex_op1, 32'd5);
    check("plain_op2", ex_op2, 32'd7);
    step();

    // EX and MEM forwarding
    fwd_ex_ex1 = 1; fwd_mem_ex2 = 1; mem_rdata = 32'h99; ex_alu_result = 32'h55;
    id_pc = 32'h108;
    #1;
    check("fwd_ex_op1", ex_op1, 32'h2A);
    check("fwd_mem_op2", ex_op2, 32'h99);
    fwd_mem_ex1 = 1;
    #1;
    check("fwd_both_op1", ex_op1, 32'h2A);
    step();

    // Load-use stall
    idle_inputs();
    id_valid = 1; id_pc = 32'h10C; stall = 1; ex_alu_result = 32'h77;
    #1;
    check("stall_valid", {31'b0, ex_valid}, 32'd0);
    check("stall_ready", {31'b0, id_ready}, 32'd0);
    step();
    stall = 0; fwd_ex_ex1 = 1;
    #1;
    check("replay_valid", {31'b0, ex_valid}, 32'd1);
    check("replay_pc", ex_pc, 32'h108);
    check("replay_cnt", {16'b0, stall_cycles}, 32'd1);
    check("replay_prev", ex_op1, 32'h55);
    step();

    // Flush together with stall
    idle_inputs();
    flush = 1; stall = 1;
    step();
    flush = 0; stall = 0;
    #1;
    check("flush_valid", {31'b0, ex_valid}, 32'd0);
    check("flush_inst", ex_inst, Nop);
    check("flush_cnt", {16'b0, stall_cycles}, 32'd2);
    step();

    // Timeout: five consecutive stall edges
    stall = 1;
    repeat (4) step();
    #1;
    check("timeout_4", {31'b0, stall_timeout}, 32'd0);
    step();
    stall = 0;
    #1;
    check("timeout_5", {31'b0, stall_timeout}, 32'd1);
    step();
    #1;
    check("timeout_sticky", {31'b0, stall_timeout}, 32'd1);

    // Saturation of the 4-bit counter
    stall = 1;
    repeat (20) step();
    stall = 0;
    #1;
    check("sat_w4", {28'b0, s_stall_cycles}, 32'd15);
    step();

    // Asynchronous reset between edges
    id_valid = 1; id_pc = 32'h200; id_rs1_data = 32'hDEAD;
    step();
    #2;
    rst = 0;
    #1;
    check("rst_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_inst", ex_inst, Nop);
    check("rst_op1", ex_op1, 32'd0);
    check("rst_cnt", {16'b0, stall_cycles}, 32'd0);
    check("rst_timeout", {31'b0, stall_timeout}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_valid      = 1'($urandom_range(1));
      id_pc         = $urandom;
      id_inst       = $urandom;
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      stall         = ($urandom_range(3) == 0);
      flush         = ($urandom_range(9) == 0);
      fwd_ex_ex1    = 1'($urandom_range(1));
      fwd_ex_ex2    = 1'($urandom_range(1));
      fwd_mem_ex1   = 1'($urandom_range(1));
      fwd_mem_ex2   = 1'($urandom_range(1));
      mem_rdata     = $urandom;
      ex_alu_result = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
